// File: rtl/multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_ctrl_if
//  Brief    : Bundle of the pipeline request/result signals and the
//             multiply/divide datapath handshake seen by multdiv_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface multdiv_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   // pipeline request side
   logic             op_mult;
   logic             op_div;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [TAG_W-1:0] op_rd;
   // datapath side
   logic [WIDTH-1:0] unit_a;
   logic [WIDTH-1:0] unit_b;
   logic             unit_start_mult;
   logic             unit_start_div;
   logic [WIDTH-1:0] unit_result;
   logic             unit_exception;
   logic             unit_rdy;
   // pipeline result side
   logic             stall;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] result_rd;
   logic             result_exc;
   logic             result_valid;

   // controller view
   modport slave (
      input  op_mult, op_div, op_a, op_b, op_rd,
      input  unit_result, unit_exception, unit_rdy,
      output unit_a, unit_b, unit_start_mult, unit_start_div,
      output stall, result, result_rd, result_exc, result_valid
   );

   // environment view (pipeline plus datapath)
   modport master (
      output op_mult, op_div, op_a, op_b, op_rd,
      output unit_result, unit_exception, unit_rdy,
      input  unit_a, unit_b, unit_start_mult, unit_start_div,
      input  stall, result, result_rd, result_exc, result_valid
   );
endinterface
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_ctrl
//  Brief    : Sequences one MULT/DIV request at a time through the shared
//             datapath: latches operands, pulses start, waits on ready with
//             a watchdog, returns a tagged result. Divide-by-zero is trapped
//             without starting the divider.
//  Revision : 1.0  initial release
// ============================================================================
module multdiv_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40
) (
   input  wire logic        clk_i,
   input  wire logic        clr_i,
   multdiv_ctrl_if.slave    bus_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int                CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             timeout_hit;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [TAG_W-1:0] rd_q;
   logic             start_mult_q;
   logic             start_div_q;
   logic [WIDTH-1:0] result_q;
   logic [TAG_W-1:0] result_rd_q;
   logic             result_exc_q;
   logic             result_valid_q;
   logic             req;

   assign req = bus_if.op_mult | bus_if.op_div;

   // Saturating wait counter; the watchdog fires on the cycle it reaches TIMEOUT
   always_comb begin
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      timeout_hit = (cnt_d == CNT_MAX);
   end

   // Main sequencer with registered datapath and result outputs
   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         rd_q           <= '0;
         start_mult_q   <= 1'b0;
         start_div_q    <= 1'b0;
         result_q       <= '0;
         result_rd_q    <= '0;
         result_exc_q   <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         start_mult_q   <= 1'b0;
         start_div_q    <= 1'b0;
         result_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  a_q  <= bus_if.op_a;
                  b_q  <= bus_if.op_b;
                  rd_q <= bus_if.op_rd;
                  // multiply has priority when both requests are raised
                  if (!bus_if.op_mult && (bus_if.op_b == '0)) begin
                     result_q       <= '0;
                     result_exc_q   <= 1'b1;
                     result_rd_q    <= bus_if.op_rd;
                     result_valid_q <= 1'b1;
                     state_q        <= S_DONE;
                  end else begin
                     start_mult_q <= bus_if.op_mult;
                     start_div_q  <= !bus_if.op_mult;
                     state_q      <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // ready may still be high from the previous operation
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               if (bus_if.unit_rdy) begin
                  result_q       <= bus_if.unit_result;
                  result_exc_q   <= bus_if.unit_exception;
                  result_rd_q    <= rd_q;
                  result_valid_q <= 1'b1;
                  state_q        <= S_DONE;
               end else if (timeout_hit) begin
                  result_q       <= '0;
                  result_exc_q   <= 1'b1;
                  result_rd_q    <= rd_q;
                  result_valid_q <= 1'b1;
                  state_q        <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_if.unit_a          = a_q;
   assign bus_if.unit_b          = b_q;
   assign bus_if.unit_start_mult = start_mult_q;
   assign bus_if.unit_start_div  = start_div_q;
   assign bus_if.result          = result_q;
   assign bus_if.result_rd       = result_rd_q;
   assign bus_if.result_exc      = result_exc_q;
   assign bus_if.result_valid    = result_valid_q;
   // low in DONE so the pipeline advances together with result_valid
   assign bus_if.stall           = ((state_q == S_IDLE) && req) ||
                                   (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_ctrl
//  Brief    : Directed self-checking bench for multdiv_ctrl with a simple
//             datapath model that raises ready a fixed number of cycles
//             after the start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_ctrl;

   localparam int WIDTH   = 32;
   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 40;

   logic clk;
   logic clr;
   int   n_tests;
   int   n_fail;

   multdiv_ctrl_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   multdiv_ctrl #(
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i  (clk),
      .clr_i  (clr),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One complete request. n_rdy < 0 means the unit never answers; otherwise
   // ready is raised in cycle 1+n_rdy (start pulse is cycle 1, accept cycle 0).
   // stale keeps ready high from the accept cycle up to that point.
   task automatic run_op(input string name, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int n_rdy, input bit stale,
                         input logic [31:0] ures, input logic uexc,
                         input logic [31:0] eres, input logic eexc,
                         input int elat, input int e_sm, input int e_sd);
      int          sm;
      int          sd;
      int          st;
      int          lat;
      logic [31:0] ua;
      logic [31:0] ub;
      logic [31:0] gres;
      logic [4:0]  grd;
      logic        gexc;
      sm = 0; sd = 0; st = 0; lat = -1;
      ua = '0; ub = '0; gres = '0; grd = '0; gexc = 1'b0;
      @(negedge clk);
      bus.op_mult = m;
      bus.op_div  = d;
      bus.op_a    = a;
      bus.op_b    = b;
      bus.op_rd   = rd;
      for (int k = 0; k < 100 && lat < 0; k++) begin
         if (k > 0) @(negedge clk);
         bus.unit_rdy       = (n_rdy >= 0) && ((k == 1 + n_rdy) || (stale && k <= 1 + n_rdy));
         bus.unit_result    = ures;
         bus.unit_exception = uexc;
         #1;
         sm += int'(bus.unit_start_mult);
         sd += int'(bus.unit_start_div);
         st += int'(bus.stall);
         if (k == 1) begin
            ua = bus.unit_a;
            ub = bus.unit_b;
         end
         if (bus.result_valid) begin
            lat  = k;
            gres = bus.result;
            grd  = bus.result_rd;
            gexc = bus.result_exc;
            bus.op_mult  = 1'b0;
            bus.op_div   = 1'b0;
            bus.unit_rdy = 1'b0;
         end
      end
      check_eq({name, ".latency"}, 64'(lat), 64'(elat));
      check_eq({name, ".result"}, 64'(gres), 64'(eres));
      check_eq({name, ".rd"}, 64'(grd), 64'(rd));
      check_eq({name, ".exc"}, 64'(gexc), 64'(eexc));
      check_eq({name, ".start_mult"}, 64'(sm), 64'(e_sm));
      check_eq({name, ".start_div"}, 64'(sd), 64'(e_sd));
      check_eq({name, ".stall_cycles"}, 64'(st), 64'(elat));
      check_eq({name, ".unit_a"}, 64'(ua), 64'(a));
      check_eq({name, ".unit_b"}, 64'(ub), 64'(b));
      @(negedge clk);
      #1;
      check_eq({name, ".valid_drop"}, 64'(bus.result_valid), 64'd0);
      check_eq({name, ".stall_idle"}, 64'(bus.stall), 64'd0);
      check_eq({name, ".result_hold"}, 64'(bus.result), 64'(eres));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clr = 1'b1;
      bus.op_mult = 1'b0;
      bus.op_div  = 1'b0;
      bus.op_a    = '0;
      bus.op_b    = '0;
      bus.op_rd   = '0;
      bus.unit_result    = '0;
      bus.unit_exception = 1'b0;
      bus.unit_rdy       = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset.unit_a", 64'(bus.unit_a), 64'd0);
      check_eq("reset.result", 64'(bus.result), 64'd0);
      check_eq("reset.valid", 64'(bus.result_valid), 64'd0);
      check_eq("reset.stall", 64'(bus.stall), 64'd0);
      check_eq("reset.starts", 64'({bus.unit_start_mult, bus.unit_start_div}), 64'd0);
      @(negedge clk);
      clr = 1'b0;

      //      name      m     d     a             b      rd  n_rdy    stale ures          uexc  eres          eexc  lat           sm sd
      run_op("mul",     1'b1, 1'b0, 32'd6,        32'd7, 5'd3,  17,    1'b0, 32'd42,       1'b0, 32'd42,       1'b0, 19,           1, 0);
      run_op("div",     1'b0, 1'b1, 32'd100,      32'd7, 5'd9,  33,    1'b0, 32'd14,       1'b0, 32'd14,       1'b0, 35,           0, 1);
      run_op("div0",    1'b0, 1'b1, 32'd55,       32'd0, 5'd4,  -1,    1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1,            0, 0);
      run_op("mul_ovf", 1'b1, 1'b0, 32'h8000_0000,32'd2, 5'd17, 2,     1'b0, 32'd0,        1'b1, 32'd0,        1'b1, 4,            1, 0);
      run_op("tmo",     1'b1, 1'b0, 32'd3,        32'd4, 5'd21, -1,    1'b0, 32'd12,       1'b0, 32'd0,        1'b1, TIMEOUT + 2,  1, 0);
      run_op("tmo_rdy", 1'b1, 1'b0, 32'd3,        32'd5, 5'd22, TIMEOUT,1'b0,32'h1234,     1'b0, 32'h1234,     1'b0, TIMEOUT + 2,  1, 0);
      run_op("stale",   1'b1, 1'b1, 32'd5,        32'd0, 5'd31, 1,     1'b1, 32'hDEAD_0000,1'b0, 32'hDEAD_0000,1'b0, 3,            1, 0);

      // abort a multiply five cycles after accept
      @(negedge clk);
      bus.op_mult = 1'b1;
      bus.op_a    = 32'd3;
      bus.op_b    = 32'd5;
      bus.op_rd   = 5'd7;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      bus.op_mult = 1'b0;
      #1;
      check_eq("abort.unit_a", 64'(bus.unit_a), 64'd0);
      check_eq("abort.unit_b", 64'(bus.unit_b), 64'd0);
      check_eq("abort.result", 64'(bus.result), 64'd0);
      check_eq("abort.rd", 64'(bus.result_rd), 64'd0);
      check_eq("abort.stall", 64'(bus.stall), 64'd0);
      check_eq("abort.valid", 64'(bus.result_valid), 64'd0);
      @(negedge clk);
      clr = 1'b0;
      bus.unit_rdy = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check_eq("abort.no_valid", 64'(bus.result_valid), 64'd0);
      end
      bus.unit_rdy = 1'b0;

      run_op("post_rst",1'b1, 1'b0, 32'd9,        32'd9, 5'd12, 3,     1'b0, 32'd81,       1'b0, 32'd81,       1'b0, 5,            1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller between the pipeline's execute stage and the shared multiply/divide datapath.
- Accepts one MULT or DIV request at a time, latches operands and destination tag, and pulses the unit's start line.
- Waits on the unit's ready flag, with a watchdog, and returns a tagged result with exception flag.
- Holds the pipeline stalled for the whole operation; traps divide-by-zero without starting the divider.

Parameters:
- WIDTH, 32, operand/result width
- TAG_W, 5, destination register tag width
- TIMEOUT, 40, max WAIT cycles before forced exception completion

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- op_mult  in  1  multiply request level, held by pipeline until result_valid
- op_div  in  1  divide request level, same rule
- op_a  in  WIDTH  operand A (multiplicand/dividend)
- op_b  in  WIDTH  operand B (multiplier/divisor)
- op_rd  in  TAG_W  destination tag
- unit_a  out  WIDTH  latched operand A to datapath
- unit_b  out  WIDTH  latched operand B to datapath
- unit_start_mult  out  1  one-cycle start pulse to multiplier
- unit_start_div  out  1  one-cycle start pulse to divider
- unit_result  in  WIDTH  datapath result
- unit_exception  in  1  datapath exception (overflow/div error)
- unit_rdy  in  1  datapath result ready
- stall  out  1  freeze upstream pipeline
- result  out  WIDTH  registered result
- result_rd  out  TAG_W  registered destination tag
- result_exc  out  1  registered exception flag
- result_valid  out  1  one-cycle completion strobe

Behaviour:
- Reset (clr high, async):
  - state=IDLE; all registered outputs 0 (unit_a, unit_b, result, result_rd, result_exc, result_valid, start pulses); cycle counter 0.
  - Reset mid-operation aborts silently: no result_valid.
- States: IDLE, ISSUE, WAIT, DONE. Requests are accepted only in IDLE.
- IDLE accept (op_mult|op_div sampled at edge):
  - Latch op_a, op_b, op_rd and op kind (is_div).
  - Both requests high: multiply wins, divide is ignored.
  - op_div with op_b==0: go directly to DONE with result=0, result_exc=1; no start pulse.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - unit_start_mult or unit_start_div = 1 per kind; the other stays 0.
  - Counter cleared to 0; unit_rdy ignored (may be stale from previous op).
  - Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - On unit_rdy=1: capture unit_result into result and unit_exception into result_exc; go to DONE.
  - If counter reaches TIMEOUT with no unit_rdy: result=0, result_exc=1; go to DONE.
  - unit_rdy on the same cycle as the timeout hit: unit_rdy wins.
- DONE (exactly 1 cycle):
  - result_valid=1; result, result_rd and result_exc stable; next state IDLE.
  - Requests present in DONE belong to the next instruction and are not accepted until IDLE.
- result/result_rd/result_exc hold their values until the next completion; result_valid is 0 outside DONE.
- stall = (IDLE & (op_mult|op_div)) | ISSUE | WAIT. Combinational; low in DONE so the pipeline advances on result_valid.
- unit_a/unit_b change only on IDLE accept.
- Latency: unit_rdy seen N cycles after the start pulse gives result_valid at accept+N+2; div-by-zero gives result_valid 1 cycle after accept.
- No wrap concerns: counter width must hold TIMEOUT; it saturates and never wraps.

Test Plan:
- Multiply, normal: op_mult=1, a=6, b=7, rd=3; model raises unit_rdy 17 cycles after start with result 42 → single unit_start_mult pulse in ISSUE; stall high 19 cycles; result_valid with result=42, result_rd=3, result_exc=0.
- Divide, normal: op_div=1, a=100, b=7, rd=9; model returns 14 after 33 cycles → unit_start_div pulses once; result=14, rd=9, exc=0; unit_start_mult never asserted.
- Divide by zero: op_div=1, b=0, rd=4 → no start pulse; result_valid next cycle with result=0, exc=1, rd=4.
- Timeout: op_mult=1, model never raises unit_rdy → result_valid exactly TIMEOUT+2 cycles after accept with exc=1, result=0; rdy-same-cycle-as-timeout variant returns the unit result with exc=0.
- Stale ready and simultaneous ops: unit_rdy held high through ISSUE with op_mult=op_div=1 → ISSUE ignores rdy; multiply started; completion occurs in the first WAIT cycle.
- Reset mid-WAIT: assert clr 5 cycles into a multiply → all outputs 0 immediately; no result_valid; a fresh request after release completes normally.
